// File: rtl/clock_pkg.sv
// Shared state codes and timing constants for the clock time-setting flow.
package clock_pkg;

  // Displayed/edited field; the numeric codes are visible on the status port.
  typedef enum logic [2:0] {
    StShowTime  = 3'd0,
    StSetHour   = 3'd1,
    StSetMinute = 3'd2,
    StSetMonth  = 3'd3,
    StSetDay    = 3'd4
  } state_e;

  localparam int unsigned HoldTicks   = 50;  // 10 ms ticks before auto-repeat
  localparam int unsigned RepeatTicks = 10;  // 10 ms ticks between repeats
  localparam int unsigned BlinkTicks  = 25;  // 10 ms ticks per blink half-period
  localparam int unsigned TimeoutS    = 30;  // idle seconds before leaving an edit state

  // Field order walked by the mode key.
  function automatic state_e next_on_mode(state_e s);
    case (s)
      StShowTime:  return StSetHour;
      StSetHour:   return StSetMinute;
      StSetMinute: return StSetMonth;
      StSetMonth:  return StSetDay;
      default:     return StShowTime;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Add-key edge detect plus hold/auto-repeat timer; emits one request pulse per step.
module key_repeat #(
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,  // key is only honoured in edit states
  input  logic i_clear,   // mode press: suppress request and restart the hold timer
  input  logic i_tick,
  input  logic i_level,
  output logic o_pulse
);

  localparam int unsigned MaxTicks = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks) + 1;
  localparam logic [CntW-1:0] HoldLim = CntW'(HOLD_TICKS);
  localparam logic [CntW-1:0] RepLim  = CntW'(REPEAT_TICKS);

  logic            r_prev;
  logic            r_repeating;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;
  logic [CntW-1:0] w_lim;
  logic            w_edge;
  logic            w_reach;

  assign w_edge    = i_level & ~r_prev;
  assign w_cnt_inc = r_cnt + CntW'(1);
  assign w_lim     = r_repeating ? RepLim : HoldLim;
  // Saturating compare so a changed limit can never let the counter wrap.
  assign w_reach   = i_enable & i_level & i_tick & (w_cnt_inc >= w_lim);
  assign o_pulse   = i_enable & ~i_clear & (w_edge | w_reach);

  // Previous level and hold/repeat counter; release or mode press restarts the hold delay.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev      <= 1'b0;
      r_repeating <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_prev <= i_level;
      if (!i_enable || !i_level || i_clear) begin
        r_repeating <= 1'b0;
        r_cnt       <= '0;
      end else if (i_tick) begin
        if (w_reach) begin
          r_repeating <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: mode FSM, field increments, edit timeout, digit blink.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOLD_TICKS   = HoldTicks,
  parameter int unsigned REPEAT_TICKS = RepeatTicks,
  parameter int unsigned BLINK_TICKS  = BlinkTicks,
  parameter int unsigned TIMEOUT_S    = TimeoutS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_10ms,
  input  logic       tick_1s,
  input  logic       key_mode_press,
  input  logic       key_add_level,
  output logic [2:0] status,
  output logic       inc_hour,
  output logic       inc_minute,
  output logic       inc_month,
  output logic       inc_day,
  output logic       clear_seconds,
  output logic       run_enable,
  output logic [3:0] blank_mask
);

  localparam int unsigned ToW  = $clog2(TIMEOUT_S + 1);
  localparam int unsigned BlkW = $clog2(BLINK_TICKS + 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_S - 1);
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_TICKS - 1);

  state_e          r_state;
  state_e          w_state_next;
  logic [ToW-1:0]  r_to_cnt;
  logic [BlkW-1:0] r_blk_cnt;
  logic            r_phase;
  logic            r_edited;
  logic            r_run;
  logic            r_clear;
  logic            r_inc_hour, r_inc_minute, r_inc_month, r_inc_day;
  logic            w_edit;
  logic            w_add_pulse;
  logic            w_timeout;
  logic            w_enter_show;

  assign w_edit = r_state inside {StSetHour, StSetMinute, StSetMonth, StSetDay};

  key_repeat #(
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_key_repeat (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_enable(w_edit),
    .i_clear (key_mode_press),
    .i_tick  (tick_10ms),
    .i_level (key_add_level),
    .o_pulse (w_add_pulse)
  );

  // A held key counts as activity, so timeout and an add request never coincide.
  assign w_timeout    = w_edit & tick_1s & ~key_add_level & (r_to_cnt >= ToLast);
  assign w_enter_show = (w_state_next == StShowTime) & (r_state != StShowTime);

  // Next state: illegal codes and timeout win over the mode key.
  always_comb begin
    w_state_next = r_state;
    if (!w_edit && r_state != StShowTime) begin
      w_state_next = StShowTime;
    end else if (w_timeout) begin
      w_state_next = StShowTime;
    end else if (key_mode_press) begin
      w_state_next = next_on_mode(r_state);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= StShowTime;
    else       r_state <= w_state_next;
  end

  // Idle-seconds counter, restarted by any key activity and outside edit states.
  always_ff @(posedge clock) begin
    if (reset || !w_edit || key_mode_press || key_add_level || w_timeout) begin
      r_to_cnt <= '0;
    end else if (tick_1s) begin
      r_to_cnt <= r_to_cnt + ToW'(1);
    end
  end

  // Blink phase generator, parked at phase 0 while showing the time.
  always_ff @(posedge clock) begin
    if (reset || !w_edit) begin
      r_blk_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (tick_10ms) begin
      if (r_blk_cnt >= BlkLast) begin
        r_blk_cnt <= '0;
        r_phase   <= ~r_phase;
      end else begin
        r_blk_cnt <= r_blk_cnt + BlkW'(1);
      end
    end
  end

  // Increment requests, edited flag, run enable and the seconds-clear pulse on exit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inc_hour   <= 1'b0;
      r_inc_minute <= 1'b0;
      r_inc_month  <= 1'b0;
      r_inc_day    <= 1'b0;
      r_edited     <= 1'b0;
      r_run        <= 1'b1;
      r_clear      <= 1'b0;
    end else begin
      r_inc_hour   <= w_add_pulse & (r_state == StSetHour);
      r_inc_minute <= w_add_pulse & (r_state == StSetMinute);
      r_inc_month  <= w_add_pulse & (r_state == StSetMonth);
      r_inc_day    <= w_add_pulse & (r_state == StSetDay);
      if (w_enter_show) begin
        r_run    <= 1'b1;
        r_clear  <= r_edited;
        r_edited <= 1'b0;
      end else begin
        r_clear <= 1'b0;
        if (w_add_pulse) begin
          r_run    <= 1'b0;
          r_edited <= 1'b1;
        end
      end
    end
  end

  // Blank the field being edited on the off phase; keep digits solid while add is held.
  always_comb begin
    blank_mask = 4'b0000;
    if (r_phase && !key_add_level) begin
      case (r_state)
        StSetHour, StSetMonth: blank_mask = 4'b1100;
        StSetMinute, StSetDay: blank_mask = 4'b0011;
        default:               blank_mask = 4'b0000;
      endcase
    end
  end

  assign status        = r_state;
  assign inc_hour      = r_inc_hour;
  assign inc_minute    = r_inc_minute;
  assign inc_month     = r_inc_month;
  assign inc_day       = r_inc_day;
  assign clear_seconds = r_clear;
  assign run_enable    = r_run;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with randomized strobe spacing and hold lengths.
module tb_clock_set_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_10ms = 1'b0;
  logic       tick_1s = 1'b0;
  logic       key_mode_press = 1'b0;
  logic       key_add_level = 1'b0;
  logic [2:0] status;
  logic       inc_hour, inc_minute, inc_month, inc_day;
  logic       clear_seconds, run_enable;
  logic [3:0] blank_mask;

  int n_vec = 0;
  int n_err = 0;
  // Running pulse/event totals, written only by the monitor below.
  int c_hour = 0, c_min = 0, c_mon = 0, c_day = 0, c_clr = 0, c_multi = 0, c_blank_held = 0;

  always #5 clock = ~clock;

  clock_set_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .tick_10ms     (tick_10ms),
    .tick_1s       (tick_1s),
    .key_mode_press(key_mode_press),
    .key_add_level (key_add_level),
    .status        (status),
    .inc_hour      (inc_hour),
    .inc_minute    (inc_minute),
    .inc_month     (inc_month),
    .inc_day       (inc_day),
    .clear_seconds (clear_seconds),
    .run_enable    (run_enable),
    .blank_mask    (blank_mask)
  );

  always @(negedge clock) begin
    if (inc_hour) c_hour++;
    if (inc_minute) c_min++;
    if (inc_month) c_mon++;
    if (inc_day) c_day++;
    if (clear_seconds) c_clr++;
    if ((int'(inc_hour) + int'(inc_minute) + int'(inc_month) + int'(inc_day)) > 1) c_multi++;
    if (key_add_level && blank_mask != 4'b0000) c_blank_held++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 900000", $time);
    $fatal(1, "watchdog expired");
  end

  // One clock cycle with the given strobes; outputs are stable on return.
  task automatic cyc(input logic t10, input logic t1s, input logic md, input logic ad);
    tick_10ms = t10; tick_1s = t1s; key_mode_press = md; key_add_level = ad;
    @(posedge clock); #1;
    tick_10ms = 1'b0; tick_1s = 1'b0; key_mode_press = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; key_add_level = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic press_mode();
    repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, key_add_level);
    cyc(1'b0, 1'b0, 1'b1, key_add_level);
  endtask

  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, key_add_level);
      cyc(1'b1, 1'b0, 1'b0, key_add_level);
    end
  endtask

  task automatic send_secs(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 1'b0, key_add_level);
      cyc(1'b0, 1'b1, 1'b0, key_add_level);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    reset = 1'b0; key_add_level = 1'b0;
    n_vec++; if (status !== 3'd0) begin n_err++; $display("FAIL reset_status: got %0d want 0", status); end
    n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL reset_run: got %b want 1", run_enable); end
    n_vec++; if (blank_mask !== 4'b0000) begin n_err++; $display("FAIL reset_blank: got %b want 0000", blank_mask); end
    n_vec++;
    if ({inc_hour, inc_minute, inc_month, inc_day, clear_seconds} !== 5'b0) begin
      n_err++; $display("FAIL reset_pulses: got %b want 00000",
                        {inc_hour, inc_minute, inc_month, inc_day, clear_seconds});
    end
  endtask

  task automatic test_mode_cycle();
    int exp_st;
    int b_inc, b_clr;
    apply_reset();
    exp_st = 0;
    b_inc = c_hour + c_min + c_mon + c_day; b_clr = c_clr;
    for (int k = 0; k < 5; k++) begin
      press_mode();
      exp_st = (exp_st + 1) % 5;
      n_vec++; if (status !== 3'(exp_st)) begin n_err++; $display("FAIL mode_status: got %0d want %0d", status, exp_st); end
      n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL mode_run: got %b want 1", run_enable); end
      n_vec++; if (blank_mask !== 4'b0000) begin n_err++; $display("FAIL mode_blank: got %b want 0000", blank_mask); end
    end
    n_vec++;
    if (c_hour + c_min + c_mon + c_day - b_inc != 0) begin
      n_err++; $display("FAIL mode_no_inc: got %0d pulses want 0", c_hour + c_min + c_mon + c_day - b_inc);
    end
    n_vec++; if (c_clr - b_clr != 0) begin n_err++; $display("FAIL mode_no_clear: got %0d want 0", c_clr - b_clr); end
  endtask

  task automatic test_blink();
    int n_blk, n;
    logic [3:0] exp_m;
    // Hour field: blank the left pair on odd half-periods.
    apply_reset();
    press_mode();
    n_blk = 0;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(5, 40);
      send_ticks(n);
      n_blk += n;
      exp_m = (((n_blk / 25) % 2) == 1) ? 4'b1100 : 4'b0000;
      n_vec++; if (blank_mask !== exp_m) begin n_err++; $display("FAIL blink_hour: got %b want %b after %0d ticks", blank_mask, exp_m, n_blk); end
    end
    repeat (4) press_mode();
    n_vec++; if (blank_mask !== 4'b0000) begin n_err++; $display("FAIL blink_show: got %b want 0000", blank_mask); end
    // Minute field reached with no ticks spent in the hour field.
    press_mode(); press_mode();
    n = $urandom_range(25, 49);
    send_ticks(n);
    n_vec++; if (blank_mask !== 4'b0011) begin n_err++; $display("FAIL blink_minute: got %b want 0011 after %0d ticks", blank_mask, n); end
    key_add_level = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    n_vec++; if (blank_mask !== 4'b0000) begin n_err++; $display("FAIL blink_held: got %b want 0000", blank_mask); end
    key_add_level = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tap_minute();
    int b_h, b_m, b_o, b_d, b_c, len;
    apply_reset();
    press_mode(); press_mode();
    b_h = c_hour; b_m = c_min; b_o = c_mon; b_d = c_day;
    len = $urandom_range(1, 5);
    key_add_level = 1'b1;
    send_ticks(len);
    key_add_level = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (c_min - b_m != 1) begin n_err++; $display("FAIL tap_minute_count: got %0d want 1", c_min - b_m); end
    n_vec++;
    if (c_hour - b_h + c_mon - b_o + c_day - b_d != 0) begin
      n_err++; $display("FAIL tap_other_fields: got %0d want 0", c_hour - b_h + c_mon - b_o + c_day - b_d);
    end
    n_vec++; if (run_enable !== 1'b0) begin n_err++; $display("FAIL tap_run_low: got %b want 0", run_enable); end
    press_mode(); press_mode();
    b_c = c_clr;
    press_mode();
    n_vec++; if (status !== 3'd0) begin n_err++; $display("FAIL tap_exit_status: got %0d want 0", status); end
    n_vec++; if (clear_seconds !== 1'b1) begin n_err++; $display("FAIL tap_exit_clear: got %b want 1", clear_seconds); end
    n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL tap_exit_run: got %b want 1", run_enable); end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (clear_seconds !== 1'b0) begin n_err++; $display("FAIL tap_clear_len: got %b want 0", clear_seconds); end
    n_vec++; if (c_clr - b_c != 1) begin n_err++; $display("FAIL tap_clear_count: got %0d want 1", c_clr - b_c); end
  endtask

  task automatic test_hold_hour();
    int b_h, b_other, b_bl, hold, exp_n;
    apply_reset();
    press_mode();
    for (int it = 0; it < 3; it++) begin
      hold = (it == 0) ? 100 : $urandom_range(30, 130);
      // Press gives one step; then one at 50 ticks and every 10 ticks after.
      exp_n = 1 + ((hold >= 50) ? (1 + (hold - 50) / 10) : 0);
      b_h = c_hour; b_other = c_min + c_mon + c_day; b_bl = c_blank_held;
      key_add_level = 1'b1;
      send_ticks(hold);
      key_add_level = 1'b0;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (c_hour - b_h != exp_n) begin n_err++; $display("FAIL hold_hour_count: got %0d want %0d for %0d ticks", c_hour - b_h, exp_n, hold); end
      n_vec++; if (c_min + c_mon + c_day - b_other != 0) begin n_err++; $display("FAIL hold_other_fields: got %0d want 0", c_min + c_mon + c_day - b_other); end
      n_vec++; if (c_blank_held - b_bl != 0) begin n_err++; $display("FAIL hold_blank: got %0d blanked cycles want 0", c_blank_held - b_bl); end
    end
    n_vec++; if (c_multi != 0) begin n_err++; $display("FAIL one_hot_inc: got %0d multi-pulse cycles want 0", c_multi); end
  endtask

  task automatic test_timeout();
    int b_c, b_d;
    // Idle in SET_DAY with nothing edited.
    apply_reset();
    repeat (4) press_mode();
    b_c = c_clr;
    send_secs(29);
    n_vec++; if (status !== 3'd4) begin n_err++; $display("FAIL to_idle_29: got %0d want 4", status); end
    send_secs(1);
    n_vec++; if (status !== 3'd0) begin n_err++; $display("FAIL to_idle_30: got %0d want 0", status); end
    n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL to_idle_run: got %b want 1", run_enable); end
    n_vec++; if (c_clr - b_c != 0) begin n_err++; $display("FAIL to_idle_clear: got %0d want 0", c_clr - b_c); end
    // One add tap after second 29 restarts the timeout.
    apply_reset();
    repeat (4) press_mode();
    b_d = c_day;
    send_secs(29);
    key_add_level = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    key_add_level = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    send_secs(1);
    n_vec++; if (status !== 3'd4) begin n_err++; $display("FAIL to_edit_30: got %0d want 4", status); end
    send_secs(28);
    n_vec++; if (status !== 3'd4) begin n_err++; $display("FAIL to_edit_58: got %0d want 4", status); end
    b_c = c_clr;
    send_secs(1);
    n_vec++; if (status !== 3'd0) begin n_err++; $display("FAIL to_edit_59: got %0d want 0", status); end
    n_vec++; if (clear_seconds !== 1'b1) begin n_err++; $display("FAIL to_edit_clear: got %b want 1", clear_seconds); end
    n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL to_edit_run: got %b want 1", run_enable); end
    n_vec++; if (c_day - b_d != 1) begin n_err++; $display("FAIL to_edit_inc: got %0d want 1", c_day - b_d); end
    // Mode press together with the expiring second still lands in SHOW_TIME.
    apply_reset();
    press_mode();
    send_secs(29);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++; if (status !== 3'd0) begin n_err++; $display("FAIL to_with_mode: got %0d want 0", status); end
  endtask

  task automatic test_mode_add_same();
    int b_h, b_m, b_o, b_d;
    apply_reset();
    repeat (3) press_mode();
    b_o = c_mon; b_d = c_day;
    key_add_level = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++; if (status !== 3'd4) begin n_err++; $display("FAIL same_edge_status: got %0d want 4", status); end
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    key_add_level = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (c_mon - b_o + c_day - b_d != 0) begin n_err++; $display("FAIL same_edge_inc: got %0d want 0", c_mon - b_o + c_day - b_d); end
    n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL same_edge_run: got %b want 1", run_enable); end
    // Mode press on the tick that would have produced the first repeat.
    apply_reset();
    press_mode();
    b_h = c_hour; b_m = c_min;
    key_add_level = 1'b1;
    send_ticks(49);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++; if (status !== 3'd2) begin n_err++; $display("FAIL same_rep_status: got %0d want 2", status); end
    send_ticks(49);
    key_add_level = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (c_hour - b_h != 1) begin n_err++; $display("FAIL same_rep_hour: got %0d want 1", c_hour - b_h); end
    n_vec++; if (c_min - b_m != 0) begin n_err++; $display("FAIL same_rep_minute: got %0d want 0", c_min - b_m); end
  endtask

  task automatic test_reset_mid();
    int b_h, b_c;
    apply_reset();
    press_mode();
    key_add_level = 1'b1;
    send_ticks(55);
    n_vec++; if (run_enable !== 1'b0) begin n_err++; $display("FAIL mid_pre_run: got %b want 0", run_enable); end
    b_h = c_hour; b_c = c_clr;
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    n_vec++; if (status !== 3'd0) begin n_err++; $display("FAIL mid_status: got %0d want 0", status); end
    n_vec++; if (run_enable !== 1'b1) begin n_err++; $display("FAIL mid_run: got %b want 1", run_enable); end
    n_vec++; if (clear_seconds !== 1'b0) begin n_err++; $display("FAIL mid_clear: got %b want 0", clear_seconds); end
    n_vec++; if (inc_hour !== 1'b0) begin n_err++; $display("FAIL mid_inc: got %b want 0", inc_hour); end
    key_add_level = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (c_clr - b_c != 0) begin n_err++; $display("FAIL mid_clear_count: got %0d want 0", c_clr - b_c); end
    n_vec++; if (c_hour - b_h != 0) begin n_err++; $display("FAIL mid_inc_count: got %0d want 0", c_hour - b_h); end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_blink();
    test_tap_minute();
    test_hold_hour();
    test_timeout();
    test_mode_add_same();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
